hex_text_scroller: RTL and testbench
====================================

HEX_TEXT_SCROLLER -- requirements
Module: hex_text_scroller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of seven-segment digits driven.
REQ-002 SHALL have parameter MSG_LEN, default 16, message buffer depth in characters (>= 1).
REQ-003 SHALL have parameter TICK_DIV, default 12_500_000, CLOCK_50 cycles per scroll step (4 Hz); legal range >= 2.
REQ-004 SHALL have port CLOCK_50  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port RESET_N  input  1  synchronous, active-low reset.
REQ-006 SHALL have port en  input  1  enables the automatic scroll prescaler.
REQ-007 SHALL have port dir  input  1  0 = text moves left (ptr increments), 1 = text moves right (ptr decrements).
REQ-008 SHALL have port oneshot  input  1  1 = stop after one full pass; 0 = loop forever.
REQ-009 SHALL have port step  input  1  single-cycle pulse forcing one scroll step.
REQ-010 SHALL have port msg_len  input  $clog2(MSG_LEN+1)  active message length in characters.
REQ-011 SHALL have ports wr_en (1), wr_addr ($clog2(MSG_LEN)), wr_data (5)  inputs  message buffer write port.
REQ-012 SHALL have port hex  output  7*NUM_DIGITS  active-low segments; digit k at bits [7k+6:7k], bit 0 = seg a ... bit 6 = seg g; digit NUM_DIGITS-1 is leftmost.
REQ-013 SHALL have ports ptr  output  $clog2(MSG_LEN)  current scroll offset; wrap  output  1  one-cycle pulse on pointer wrap; done  output  1  one-shot pass complete.

Function
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 while en=1, emit internal tick on cycle where count = TICK_DIV-1, then return to 0; SHALL hold its value while en=0 or done=1.
REQ-015 Advance event = tick OR step; tick and step in the same cycle SHALL produce exactly one advance.
REQ-016 With L = min(msg_len, MSG_LEN): on advance, dir=0 SHALL set ptr to ptr+1, wrapping L-1 -> 0; dir=1 SHALL set ptr to ptr-1, wrapping 0 -> L-1.
REQ-017 wrap SHALL pulse high for the single cycle after any advance that wrapped ptr (either direction).
REQ-018 With oneshot=1, the wrapping advance SHALL set done=1; while done=1 advances SHALL be ignored; done SHALL clear when oneshot is deasserted or on reset.
REQ-019 Digit k SHALL display glyph of buffer[(ptr + NUM_DIGITS-1-k) mod L]; index wraps within L, so messages shorter than NUM_DIGITS repeat.
REQ-020 hex SHALL be registered: one cycle latency from ptr, buffer, or msg_len change to hex update.
REQ-021 L = 0 SHALL blank all digits (all ones), hold ptr at 0, suppress wrap and done.
REQ-022 If ptr >= L (msg_len reduced), ptr SHALL be forced to 0 on the next cycle with no wrap pulse; this SHALL take priority over an advance in that cycle.
REQ-023 Write SHALL update buffer[wr_addr] on the clock edge; wr_addr >= MSG_LEN SHALL be ignored; a displayed character rewritten SHALL appear on hex one cycle after the write edge.
REQ-024 Glyph map (active-low, g..a): 0x00-0x0F hex digits (0 = 1000000, 5/S = 0010010), 0x10 blank = 1111111, 0x11 L = 1000111, 0x12 o = 0100011, 0x13 r = 0101111, 0x14 c = 0100111, 0x15 H = 0001001, 0x16 dash = 0111111; codes 0x17-0x1F SHALL render blank.

Reset
REQ-025 While RESET_N=0 at a clock edge: prescaler=0, ptr=0, wrap=0, done=0, all buffer entries = 0x10, hex = all ones.
REQ-026 Reset asserted mid-operation SHALL override any simultaneous advance or write; scrolling resumes from ptr=0 with full prescaler period after release.

Structure
REQ-027 Package hex_scroller_pkg SHALL hold the 5-bit character code type, glyph constants and the code-to-segment table of REQ-024.
REQ-028 Sub-module char_to_seg (combinational, 5-bit code -> 7-bit active-low segments) SHALL be instantiated once per digit.
REQ-029 Prescaler, pointer, buffer and output register SHALL reside in hex_text_scroller; no ripple clocks, all logic on CLOCK_50.

Verification (TICK_DIV=4, NUM_DIGITS=6, MSG_LEN=16)
REQ-030 Reset, load "5croLL" (05,14,13,12,11,11), msg_len=6, en=0 -> hex = 0010010_0100111_0101111_0100011_1000111_1000111, HEX0 = L.
REQ-031 en=1, dir=0, msg_len=8 -> ptr advances every 4 cycles 0..7 -> 0, wrap pulses once per 32 cycles, leftmost digit shows buffer[ptr].
REQ-032 dir=1 from ptr=0 with step pulse -> ptr=7, wrap=1 next cycle; step coincident with tick -> ptr changes by exactly 1.
REQ-033 oneshot=1, msg_len=3 -> done set after third advance, ptr=0 held, further ticks/steps ignored; oneshot=0 -> done clears, scrolling resumes.
REQ-034 ptr=10, msg_len changed 16 -> 4 -> ptr=0 next cycle, no wrap; msg_len=0 -> hex all ones.
REQ-035 RESET_N low mid-scroll with wr_en high -> ptr=0, buffer blank, hex all ones next cycle; write discarded.

Source files
------------

// File: rtl/hex_text_scroller_pkg.sv
// Character codes and the active-low segment table
// shared by the scroller and its glyph decoder.
package hex_scroller_pkg;

  typedef logic [4:0] char_t;
  typedef logic [6:0] seg_t;

  localparam char_t CH_BLANK = 5'h10;
  localparam char_t CH_L     = 5'h11;
  localparam char_t CH_O     = 5'h12;
  localparam char_t CH_R     = 5'h13;
  localparam char_t CH_C     = 5'h14;
  localparam char_t CH_H     = 5'h15;
  localparam char_t CH_DASH  = 5'h16;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Bit order g..a, low means segment lit
  localparam seg_t SEG_LUT [32] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110,
    SEG_BLANK,  7'b1000111, 7'b0100011, 7'b0101111,
    7'b0100111, 7'b0001001, 7'b0111111, SEG_BLANK,
    SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK,
    SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
  };

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hex_text_scroller_if.sv
// Message buffer write bus between a loader
// and the scroller.
interface hex_text_scroller_if #(
  parameter int PW = 4
);
  import hex_scroller_pkg::*;

  logic          wr_en;
  logic [PW-1:0] wr_addr;
  char_t         wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );

endinterface

// File: rtl/hex_text_scroller_char_to_seg.sv
// Character code to active-low seven-segment
// pattern, purely combinational.
module char_to_seg
  import hex_scroller_pkg::*;
(
  input  char_t i_code,
  output seg_t  o_seg
);

  assign o_seg = SEG_LUT[i_code];

endmodule

// File: rtl/hex_text_scroller.sv
// Scrolling text window over a small character
// buffer, rendered onto a row of 7-seg digits.
module hex_text_scroller
  import hex_scroller_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 16,
  parameter int TICK_DIV   = 12_500_000,
  localparam int PW = ptr_w(MSG_LEN),
  localparam int LW = $clog2(MSG_LEN + 1),
  localparam int CW = $clog2(TICK_DIV)
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic                    en,
  input  logic                    dir,
  input  logic                    oneshot,
  input  logic                    step,
  input  logic [LW-1:0]           msg_len,
  input  logic                    wr_en,
  input  logic [PW-1:0]           wr_addr,
  input  logic [4:0]              wr_data,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic [PW-1:0]           ptr,
  output logic                    wrap,
  output logic                    done
);

  logic [CW-1:0]           r_cnt;
  logic [PW-1:0]           r_ptr;
  logic                    r_wrap;
  logic                    r_done;
  logic [7*NUM_DIGITS-1:0] r_hex;
  char_t                   r_buf [MSG_LEN];

  logic [LW-1:0]           w_len;
  logic [31:0]             w_div;
  logic                    w_tick;
  logic                    w_oor;
  logic                    w_last;
  logic                    w_zero;
  logic                    w_adv;
  logic                    w_wrapped;
  logic [7*NUM_DIGITS-1:0] w_seg;

  assign w_len = (msg_len > LW'(MSG_LEN)) ?
                 LW'(MSG_LEN) : msg_len;
  assign w_div = (w_len == '0) ? 32'd1 : 32'(w_len);

  assign w_tick = en && !r_done &&
                  (r_cnt == CW'(TICK_DIV - 1));

  // Out-of-range also covers an empty message
  assign w_oor  = LW'(r_ptr) >= w_len;
  assign w_last = LW'(r_ptr) == (w_len - 1'b1);
  assign w_zero = (r_ptr == '0);

  assign w_adv     = (w_tick || step) && !r_done && !w_oor;
  assign w_wrapped = w_adv && (dir ? w_zero : w_last);

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_cnt <= '0;
    end else if (en && !r_done) begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_ptr  <= '0;
      r_wrap <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_wrap <= w_wrapped;
      if (w_oor) begin
        r_ptr <= '0;
      end else if (w_adv) begin
        if (dir) begin
          r_ptr <= w_zero ? PW'(w_len - 1'b1)
                          : r_ptr - 1'b1;
        end else begin
          r_ptr <= w_last ? '0 : r_ptr + 1'b1;
        end
      end
      if (!oneshot) begin
        r_done <= 1'b0;
      end else if (w_wrapped) begin
        r_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        r_buf[i] <= CH_BLANK;
      end
    end else begin
      for (int i = 0; i < MSG_LEN; i++) begin
        if (wr_en && (wr_addr == PW'(i))) begin
          r_buf[i] <= wr_data;
        end
      end
    end
  end

  // Leftmost digit shows buffer[ptr]; index wraps in L
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    logic [31:0] w_idx;
    char_t       w_chr;

    assign w_idx = (32'(r_ptr) + 32'(NUM_DIGITS - 1 - k))
                   % w_div;

    always_comb begin
      w_chr = CH_BLANK;
      for (int j = 0; j < MSG_LEN; j++) begin
        if (w_idx == 32'(j)) begin
          w_chr = r_buf[j];
        end
      end
    end

    char_to_seg u_seg (
      .i_code (w_chr),
      .o_seg  (w_seg[7*k +: 7])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_hex <= '1;
    end else begin
      r_hex <= (w_len == '0) ? '1 : w_seg;
    end
  end

  assign hex  = r_hex;
  assign ptr  = r_ptr;
  assign wrap = r_wrap;
  assign done = r_done;

endmodule

// File: tb/tb_hex_text_scroller.sv
// Directed and randomized checks of the scroller
// against a cycle-level reference model.
module tb_hex_text_scroller;

  localparam int ND = 6;
  localparam int ML = 16;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        dir;
  logic        oneshot;
  logic        step;
  logic [4:0]  msg_len;
  logic [41:0] hex;
  logic [3:0]  ptr;
  logic        wrap;
  logic        done;

  always #5 clk = ~clk;

  hex_text_scroller_if #(.PW(4)) wif ();

  hex_text_scroller #(
    .NUM_DIGITS (ND),
    .MSG_LEN    (ML),
    .TICK_DIV   (TD)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .en       (en),
    .dir      (dir),
    .oneshot  (oneshot),
    .step     (step),
    .msg_len  (msg_len),
    .wr_en    (wif.wr_en),
    .wr_addr  (wif.wr_addr),
    .wr_data  (wif.wr_data),
    .hex      (hex),
    .ptr      (ptr),
    .wrap     (wrap),
    .done     (done)
  );

  int checks = 0;
  int errors = 0;

  int          m_cnt;
  int          m_ptr;
  bit          m_wrap;
  bit          m_done;
  logic [4:0]  m_buf [ML];
  logic [41:0] m_hex;

  function automatic logic [6:0] glyph(logic [4:0] c);
    case (c)
      5'h00: return 7'b1000000;
      5'h01: return 7'b1111001;
      5'h02: return 7'b0100100;
      5'h03: return 7'b0110000;
      5'h04: return 7'b0011001;
      5'h05: return 7'b0010010;
      5'h06: return 7'b0000010;
      5'h07: return 7'b1111000;
      5'h08: return 7'b0000000;
      5'h09: return 7'b0010000;
      5'h0A: return 7'b0001000;
      5'h0B: return 7'b0000011;
      5'h0C: return 7'b1000110;
      5'h0D: return 7'b0100001;
      5'h0E: return 7'b0000110;
      5'h0F: return 7'b0001110;
      5'h11: return 7'b1000111;
      5'h12: return 7'b0100011;
      5'h13: return 7'b0101111;
      5'h14: return 7'b0100111;
      5'h15: return 7'b0001001;
      5'h16: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] model_hex(int p, int len);
    logic [41:0] r;
    r = '1;
    if (len != 0) begin
      for (int k = 0; k < ND; k++) begin
        r[7*k +: 7] = glyph(m_buf[(p + ND - 1 - k) % len]);
      end
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit         r   = rst_n;
    bit         e   = en;
    bit         d   = dir;
    bit         o   = oneshot;
    bit         s   = step;
    bit         we  = wif.wr_en;
    int         a   = int'(wif.wr_addr);
    logic [4:0] dat = wif.wr_data;
    int         len = (int'(msg_len) > ML) ? ML : int'(msg_len);
    bit         tick;
    bit         adv;
    bit         wr;
    @(posedge clk);
    if (!r) begin
      m_cnt  = 0;
      m_ptr  = 0;
      m_wrap = 0;
      m_done = 0;
      for (int i = 0; i < ML; i++) m_buf[i] = 5'h10;
      m_hex = '1;
    end else begin
      tick = e && !m_done && (m_cnt == TD - 1);
      if (e && !m_done) m_cnt = (m_cnt + 1) % TD;
      m_hex = model_hex(m_ptr, len);
      adv = (tick || s) && !m_done && (m_ptr < len);
      wr = 0;
      if (m_ptr >= len) begin
        m_ptr = 0;
      end else if (adv) begin
        if (!d) begin
          if (m_ptr == len - 1) begin
            m_ptr = 0;
            wr = 1;
          end else begin
            m_ptr = m_ptr + 1;
          end
        end else begin
          if (m_ptr == 0) begin
            m_ptr = len - 1;
            wr = 1;
          end else begin
            m_ptr = m_ptr - 1;
          end
        end
      end
      m_wrap = wr;
      if (!o) m_done = 0;
      else if (wr) m_done = 1;
      if (we && a < ML) m_buf[a] = dat;
    end
    #1;
    chk("ptr", 64'(ptr), 64'(m_ptr));
    chk("wrap", 64'(wrap), 64'(m_wrap));
    chk("done", 64'(done), 64'(m_done));
    chk("hex", 64'(hex), 64'(m_hex));
  endtask

  logic [4:0] msg [6];
  int         wc;
  int         n;

  initial begin
    msg = '{5'h05, 5'h14, 5'h13, 5'h12, 5'h11, 5'h11};
    rst_n = 1'b0;
    en = 1'b0;
    dir = 1'b0;
    oneshot = 1'b0;
    step = 1'b0;
    msg_len = 5'd0;
    wif.wr_en = 1'b0;
    wif.wr_addr = 4'd0;
    wif.wr_data = 5'd0;
    repeat (2) cyc();
    chk("rst_ptr", 64'(ptr), 64'd0);
    chk("rst_wrap", 64'(wrap), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hex", 64'(hex), 64'(42'h3FF_FFFF_FFFF));

    // Load "5croLL"
    rst_n = 1'b1;
    msg_len = 5'd6;
    for (int i = 0; i < 6; i++) begin
      wif.wr_en = 1'b1;
      wif.wr_addr = 4'(i);
      wif.wr_data = msg[i];
      cyc();
    end
    wif.wr_en = 1'b0;
    cyc();
    chk("load_hex", 64'(hex), 64'(42'b0010010_0100111_0101111_0100011_1000111_1000111));
    chk("hex0_L", 64'(hex[6:0]), 64'(7'b1000111));

    // Auto scroll left over 8 chars
    wif.wr_en = 1'b1;
    wif.wr_addr = 4'd6;
    wif.wr_data = 5'h15;
    cyc();
    wif.wr_addr = 4'd7;
    wif.wr_data = 5'h16;
    cyc();
    wif.wr_en = 1'b0;
    msg_len = 5'd8;
    en = 1'b1;
    wc = 0;
    repeat (32) begin
      cyc();
      wc += int'(wrap);
    end
    chk("wrap_per_32", 64'(wc), 64'd1);
    chk("ptr_after_32", 64'(ptr), 64'd0);
    en = 1'b0;
    cyc();
    chk("leftmost", 64'(hex[41:35]), 64'(7'b0010010));

    // Step right from 0 wraps to 7
    dir = 1'b1;
    step = 1'b1;
    cyc();
    chk("step_wrap_ptr", 64'(ptr), 64'd7);
    chk("step_wrap_pulse", 64'(wrap), 64'd1);
    step = 1'b0;
    cyc();
    chk("wrap_single", 64'(wrap), 64'd0);
    en = 1'b1;
    repeat (3) cyc();
    step = 1'b1;
    cyc();
    chk("tick_and_step", 64'(ptr), 64'd6);
    step = 1'b0;
    en = 1'b0;

    // One-shot over 3 chars
    msg_len = 5'd3;
    cyc();
    chk("shrink_ptr", 64'(ptr), 64'd0);
    chk("shrink_nowrap", 64'(wrap), 64'd0);
    dir = 1'b0;
    oneshot = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      cyc();
      if (i == 2) begin
        chk("os_done", 64'(done), 64'd1);
        chk("os_ptr", 64'(ptr), 64'd0);
      end
      step = 1'b0;
      cyc();
    end
    en = 1'b1;
    step = 1'b1;
    cyc();
    step = 1'b0;
    repeat (8) cyc();
    chk("os_hold_ptr", 64'(ptr), 64'd0);
    chk("os_hold_done", 64'(done), 64'd1);
    oneshot = 1'b0;
    cyc();
    chk("os_clear", 64'(done), 64'd0);
    repeat (4) cyc();
    chk("os_resume", 64'(ptr), 64'd1);
    en = 1'b0;

    // Shrink from ptr=10, then empty message
    msg_len = 5'd16;
    n = (10 - m_ptr + 16) % 16;
    step = 1'b1;
    repeat (n) cyc();
    step = 1'b0;
    chk("ptr_ten", 64'(ptr), 64'd10);
    msg_len = 5'd4;
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("oor_ptr", 64'(ptr), 64'd0);
    chk("oor_nowrap", 64'(wrap), 64'd0);
    msg_len = 5'd0;
    cyc();
    cyc();
    chk("empty_hex", 64'(hex), 64'(42'h3FF_FFFF_FFFF));

    // Randomized operation
    repeat (600) begin
      rst_n = ($urandom_range(0, 99) != 0);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      step = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) oneshot = ~oneshot;
      if ($urandom_range(0, 29) == 0)
        msg_len = 5'($urandom_range(0, 20));
      wif.wr_en = ($urandom_range(0, 3) == 0);
      wif.wr_addr = 4'($urandom_range(0, 15));
      wif.wr_data = 5'($urandom_range(0, 31));
      cyc();
    end

    // Reset mid-scroll with a write pending
    rst_n = 1'b1;
    step = 1'b0;
    oneshot = 1'b0;
    wif.wr_en = 1'b0;
    msg_len = 5'd8;
    en = 1'b1;
    repeat (10) cyc();
    rst_n = 1'b0;
    wif.wr_en = 1'b1;
    wif.wr_addr = 4'd0;
    wif.wr_data = 5'h05;
    cyc();
    chk("midrst_ptr", 64'(ptr), 64'd0);
    chk("midrst_hex", 64'(hex), 64'(42'h3FF_FFFF_FFFF));
    rst_n = 1'b1;
    wif.wr_en = 1'b0;
    msg_len = 5'd6;
    en = 1'b0;
    repeat (2) cyc();
    chk("midrst_discard", 64'(hex), 64'(42'h3FF_FFFF_FFFF));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
